// File: rtl/uart_tx_periph_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
// Build option: UART_TX_PARITY_EN adds an even-parity bit to every frame.
package plm_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam logic [31:0] TXD_OFS  = 32'd0;
   localparam logic [31:0] STAT_OFS = 32'd4;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_EMPTY   = 2;
   localparam int STAT_DONE    = 3;
   localparam int STAT_OVF     = 4;
   localparam int STAT_IE      = 5;
   localparam int STAT_PAR     = 6;
   localparam int STAT_CNT_LSB = 8;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_tx_periph_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serializer; read data is show-ahead.
// DEPTH must be a power of two so the pointers wrap naturally.
module tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     sysclk,
   input  logic                     Reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt_q;

   // NOTE: the storage array has no reset; validity is tracked by the count,
   // so the array can map onto plain RAM or reset-less flops.
   always_ff @(posedge sysclk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sysclk) begin
      if (!Reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (cnt_q == FULL_CNT);
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: TXD push register, STAT register, TX FIFO,
// 8N1 serializer (8E1 when UART_TX_PARITY_EN is defined) and drain interrupt.
module uart_tx_periph
   import plm_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV   = 5208,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h40000018
) (
   input  logic        sysclk,
   input  logic        Reset_n,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx_out,
   output logic        irq
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_FLAG = 1'b1;
   logic parity_q;
`else
   localparam logic PARITY_FLAG = 1'b0;
`endif

   tx_state_e         state_q;
   tx_state_e         state_next;
   logic [BAUD_W-1:0] baud_cnt_q;
   logic [2:0]        bit_cnt_q;
   logic [7:0]        shift_q;
   logic              tx_next;
   logic              baud_wrap;
   logic              shift_en;
   logic              set_done;
   logic              done_q;
   logic              ovf_q;
   logic              ie_q;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [7:0]        fifo_data;
   logic [CNT_W-1:0]  fifo_count;

   logic              sel_txd;
   logic              sel_stat;
   logic              txd_wr;
   logic              stat_wr;
   logic [31:0]       stat_word;
   logic              unused_wdata;

   assign sel_txd  = (addr == BASE_ADDR + TXD_OFS);
   assign sel_stat = (addr == BASE_ADDR + STAT_OFS);
   assign txd_wr   = wr & sel_txd;
   assign stat_wr  = wr & sel_stat;

   // A full FIFO still accepts the byte when the serializer frees a slot this edge.
   assign fifo_push = txd_wr & (~fifo_full | fifo_pop);

   assign unused_wdata = ^wdata[31:8];

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .sysclk    (sysclk),
      .Reset_n   (Reset_n),
      .push      (fifo_push),
      .push_data (wdata[7:0]),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign baud_wrap = (baud_cnt_q == BAUD_LAST);

   // NOTE: every output of this block gets a default first, so no latches are inferred.
   always_comb begin
      state_next = state_q;
      tx_next    = tx_out;
      fifo_pop   = 1'b0;
      shift_en   = 1'b0;
      set_done   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_next = START;
               tx_next    = 1'b0;
            end
         end
         START: begin
            if (baud_wrap) begin
               state_next = DATA;
               tx_next    = shift_q[0];
               shift_en   = 1'b1;
            end
         end
         DATA: begin
            if (baud_wrap) begin
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
                  tx_next    = parity_q;
`else
                  state_next = STOP;
                  tx_next    = 1'b1;
`endif
               end else begin
                  tx_next  = shift_q[0];
                  shift_en = 1'b1;
               end
            end
         end
         PARITY: begin
            if (baud_wrap) begin
               state_next = STOP;
               tx_next    = 1'b1;
            end
         end
         STOP: begin
            if (baud_wrap) begin
               // Chain straight into the next start bit so frames have no idle gap.
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  state_next = START;
                  tx_next    = 1'b0;
               end else begin
                  state_next = IDLE;
                  set_done   = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         tx_out  <= 1'b1;
      end else begin
         state_q <= state_next;
         tx_out  <= tx_next;
      end
   end

   always_ff @(posedge sysclk) begin
      if (!Reset_n) begin
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
      end else begin
         if (state_q == IDLE || baud_wrap) baud_cnt_q <= '0;
         else                              baud_cnt_q <= baud_cnt_q + 1'b1;

         if (fifo_pop) begin
            shift_q   <= fifo_data;
            bit_cnt_q <= '0;
         end else begin
            if (shift_en) shift_q <= {1'b0, shift_q[7:1]};
            if (state_q == DATA && baud_wrap) bit_cnt_q <= bit_cnt_q + 1'b1;
         end
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge sysclk) begin
      if (!Reset_n)      parity_q <= 1'b0;
      else if (fifo_pop) parity_q <= even_parity(fifo_data);
   end
`endif

   // The FSM setting done wins over a simultaneous write-1-clear.
   always_ff @(posedge sysclk) begin
      if (!Reset_n) begin
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
         ie_q   <= 1'b0;
         irq    <= 1'b0;
      end else begin
         irq <= ie_q & done_q;
         if (stat_wr) ie_q <= wdata[STAT_IE];

         if (set_done)                       done_q <= 1'b1;
         else if (stat_wr && wdata[STAT_DONE]) done_q <= 1'b0;

         if (txd_wr && fifo_full && !fifo_pop) ovf_q <= 1'b1;
         else if (stat_wr && wdata[STAT_OVF])  ovf_q <= 1'b0;
      end
   end

   always_comb begin
      stat_word                           = '0;
      stat_word[STAT_BUSY]                = (state_q != IDLE);
      stat_word[STAT_FULL]                = fifo_full;
      stat_word[STAT_EMPTY]               = fifo_empty;
      stat_word[STAT_DONE]                = done_q;
      stat_word[STAT_OVF]                 = ovf_q;
      stat_word[STAT_IE]                  = ie_q;
      stat_word[STAT_PAR]                 = PARITY_FLAG;
      stat_word[STAT_CNT_LSB +: CNT_W]    = fifo_count;
      rdata = (rd && sel_stat) ? stat_word : 32'h0;
   end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph (BAUD_DIV=4, FIFO_DEPTH=4): directed and random
// traffic checked every cycle against a queue-based frame model.
module tb_uart_tx_periph;

   localparam int          BAUD   = 4;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] BASE   = 32'h40000018;
   localparam logic [31:0] TXD_A  = BASE;
   localparam logic [31:0] STAT_A = BASE + 32'd4;
`ifdef UART_TX_PARITY_EN
   localparam int   NBITS    = 11;
   localparam logic PAR_FLAG = 1'b1;
`else
   localparam int   NBITS    = 10;
   localparam logic PAR_FLAG = 1'b0;
`endif
   localparam int          FRAME = NBITS * BAUD;
   localparam logic [31:0] PARW  = {25'd0, PAR_FLAG, 6'd0};

   logic        sysclk  = 1'b0;
   logic        Reset_n = 1'b0;
   logic        rd      = 1'b0;
   logic        wr      = 1'b0;
   logic [31:0] addr    = '0;
   logic [31:0] wdata   = '0;
   logic [31:0] rdata;
   logic        tx_out;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_periph #(
      .BAUD_DIV   (BAUD),
      .FIFO_DEPTH (DEPTH),
      .BASE_ADDR  (BASE)
   ) dut (
      .sysclk  (sysclk),
      .Reset_n (Reset_n),
      .rd      (rd),
      .wr      (wr),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .tx_out  (tx_out),
      .irq     (irq)
   );

   always #5 sysclk = ~sysclk;

   // Reference model: a byte queue plus the position inside the frame on the line.
   byte unsigned mq[$];
   logic [7:0]   m_cur    = '0;
   bit           m_active = 1'b0;
   int           m_pos    = 0;
   bit           m_line   = 1'b1;
   bit           m_done   = 1'b0;
   bit           m_ovf    = 1'b0;
   bit           m_ie     = 1'b0;
   bit           m_irq    = 1'b0;

   function automatic bit frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (NBITS == 11 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   always @(posedge sysclk) begin : ref_model
      bit fin;
      if (!Reset_n) begin
         mq.delete();
         m_active = 1'b0;
         m_pos    = 0;
         m_line   = 1'b1;
         m_done   = 1'b0;
         m_ovf    = 1'b0;
         m_ie     = 1'b0;
         m_irq    = 1'b0;
      end else begin
         fin   = 1'b0;
         m_irq = m_ie & m_done;
         if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) begin
               m_active = 1'b0;
               fin      = 1'b1;
            end
         end
         if (!m_active && mq.size() != 0) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
         end
         m_line = m_active ? frame_bit(m_cur, m_pos / BAUD) : 1'b1;
         if (wr && addr == STAT_A) begin
            m_ie = wdata[5];
            if (wdata[3]) m_done = 1'b0;
            if (wdata[4]) m_ovf  = 1'b0;
         end
         if (fin && !m_active) m_done = 1'b1;
         if (wr && addr == TXD_A) begin
            if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
            else                   m_ovf = 1'b1;
         end
      end
   end

   function automatic logic [31:0] model_stat();
      logic [31:0] s;
      s       = '0;
      s[0]    = m_active;
      s[1]    = (mq.size() == DEPTH);
      s[2]    = (mq.size() == 0);
      s[3]    = m_done;
      s[4]    = m_ovf;
      s[5]    = m_ie;
      s[6]    = PAR_FLAG;
      s[11:8] = 4'(mq.size());
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge sysclk);
      check("tx_line", {31'd0, tx_out}, {31'd0, m_line});
      check("irq",     {31'd0, irq},    {31'd0, m_irq});
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      step();
      addr  = a;
      wdata = d;
      wr    = 1'b1;
      @(posedge sysclk);
      #1;
      wr    = 1'b0;
      addr  = '0;
      wdata = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
      step();
      addr = a;
      rd   = 1'b1;
      #1;
      v    = rdata;
      rd   = 1'b0;
      addr = '0;
   endtask

   initial begin
      logic [31:0] v;
      int          nw;

      Reset_n = 1'b0;
      repeat (3) @(posedge sysclk);
      #1;
      Reset_n = 1'b1;

      // Reset state
      bus_read(STAT_A, v);
      check("reset_stat", v, 32'h4 | PARW);
      check("reset_tx",   {31'd0, tx_out}, 32'd1);
      check("reset_irq",  {31'd0, irq},    32'd0);

      // Single frame 0x55 with exact start latency
      bus_write(TXD_A, 32'h55);
      step();
      check("tx_before_pop", {31'd0, tx_out}, 32'd1);
      step();
      check("start_bit_e1", {31'd0, tx_out}, 32'd0);
      bus_read(STAT_A, v);
      check("busy_in_frame", v, model_stat());
      check("busy_bit", {31'd0, v[0]}, 32'd1);
      idle(FRAME);
      bus_read(STAT_A, v);
      check("after_frame_stat", v, 32'h0C | PARW);

      // Six back-to-back writes: one dropped, five contiguous frames
      for (int i = 1; i <= 6; i++) bus_write(TXD_A, i);
      bus_read(STAT_A, v);
      check("burst_stat", v, model_stat());
      check("burst_ovf_full", v & 32'h0000_0F12, 32'h0000_0412);
      idle(5 * FRAME + 4);
      bus_read(STAT_A, v);
      check("burst_drained", v, 32'h1C | PARW);

      // Interrupt: enable, send, drain, then clear done with ie kept set
      bus_write(STAT_A, 32'h18);
      bus_write(STAT_A, 32'h20);
      bus_write(TXD_A, 32'hA3);
      idle(FRAME + 3);
      check("irq_high", {31'd0, irq}, 32'd1);
      bus_write(STAT_A, 32'h28);
      step();
      check("irq_still_high", {31'd0, irq}, 32'd1);
      step();
      check("irq_dropped", {31'd0, irq}, 32'd0);
      bus_read(STAT_A, v);
      check("ie_kept", v, 32'h24 | PARW);
      bus_write(STAT_A, 32'h00);

      // Reset in the middle of the data bits of 0xFF
      bus_write(TXD_A, 32'hFF);
      idle(3 * BAUD);
      step();
      Reset_n = 1'b0;
      @(posedge sysclk);
      #1;
      Reset_n = 1'b1;
      step();
      check("reset_mid_tx", {31'd0, tx_out}, 32'd1);
      bus_read(STAT_A, v);
      check("reset_mid_stat", v, 32'h4 | PARW);
      idle(FRAME);
      check("no_frame_after_reset", {31'd0, tx_out}, 32'd1);

      // Decode: unmapped, TXD read, STAT without rd
      bus_read(32'h4000_0000, v);
      check("unmapped_read", v, 32'd0);
      bus_read(TXD_A, v);
      check("txd_read", v, 32'd0);
      step();
      addr = STAT_A;
      #1;
      check("stat_no_rd", rdata, 32'd0);
      addr = '0;

`ifdef UART_TX_PARITY_EN
      bus_write(TXD_A, 32'h07);
      idle(39);
      check("parity_bit", {31'd0, tx_out}, 32'd1);
      idle(6);
      bus_read(STAT_A, v);
      check("parity_frame_done", v, 32'h4C);
`endif

      // Random traffic: bursts with random gaps, status writes and reads
      for (int r = 0; r < 6; r++) begin
         nw = $urandom_range(1, 6);
         for (int k = 0; k < nw; k++) begin
            bus_write(TXD_A, {24'd0, 8'($urandom)});
            idle($urandom_range(0, 2 * BAUD));
            if ($urandom_range(0, 2) == 0) begin
               bus_read(STAT_A, v);
               check("rand_stat", v, model_stat());
            end
         end
         if ($urandom_range(0, 1) == 1) bus_write(STAT_A, $urandom & 32'h38);
         idle((DEPTH + 1) * FRAME + 2);
         bus_read(STAT_A, v);
         check("rand_drain_stat", v, model_stat());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
